// File: rtl/write_through_buffer.sv
// write_through_buffer: write-through store buffer in front of an AXI write
// channel. Frontend stores are queued in a small circular FIFO and replayed
// one at a time; the head entry is held stable for the whole channel
// transaction and retired on the channel's completion pulse.
//
// Optional feature: define WRITE_BUFFER_COALESCE_EN to merge a store into the
// tail entry when the word address matches and the tail is not the head.
module write_through_buffer #(
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int FE_NBYTES = FE_DATA_W / 8,
    parameter int FE_BYTE_W = $clog2(FE_NBYTES),
    parameter int DEPTH_W   = 2
) (
    input  logic                           ap_clk,
    input  logic                           reset,
    input  logic                           wr_valid,
    input  logic [FE_ADDR_W-FE_BYTE_W-1:0] wr_addr,
    input  logic [FE_DATA_W-1:0]           wr_wdata,
    input  logic [FE_NBYTES-1:0]           wr_wstrb,
    output logic                           wr_ready,
    output logic                           valid,
    output logic [FE_ADDR_W-FE_BYTE_W-1:0] addr,
    output logic [FE_DATA_W-1:0]           wdata,
    output logic [FE_NBYTES-1:0]           wstrb,
    input  logic                           ready,
    output logic                           empty,
    output logic                           full
);

    localparam int WA_W  = FE_ADDR_W - FE_BYTE_W;
    localparam int DEPTH = 1 << DEPTH_W;

    localparam logic [DEPTH_W:0]   CNT_MAX = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0]   CNT_TWO = (DEPTH_W + 1)'(2);
    localparam logic [DEPTH_W:0]   CNT_ONE = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W-1:0] PTR_ONE = DEPTH_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,     // no entries
        ST_PRESENT,  // head offered, channel not yet started
        ST_BUSY      // channel transaction in flight on the head
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W:0]   count;

    logic [WA_W-1:0]      mem_addr [DEPTH];
    logic [FE_DATA_W-1:0] mem_data [DEPTH];
    logic [FE_NBYTES-1:0] mem_strb [DEPTH];

    logic wr_fire;  // frontend store taken this cycle
    logic alloc;    // store occupies a new slot
    logic pop;      // head retired this cycle
    logic more;     // entries remain after a completion

    assign full    = (count == CNT_MAX);
    assign empty   = (state == ST_IDLE);
    assign wr_fire = wr_valid & wr_ready;
    assign pop     = (state == ST_BUSY) & ready;

    // Head slot drives the channel directly; stable while the pointer holds.
    assign addr  = mem_addr[rd_ptr];
    assign wdata = mem_data[rd_ptr];
    assign wstrb = mem_strb[rd_ptr];

`ifdef WRITE_BUFFER_COALESCE_EN
    logic [DEPTH_W-1:0] tail_ptr;
    logic               tail_match;
    logic               merge;

    // The tail is only mergeable when it is distinct from the head (count>=2).
    assign tail_ptr   = wr_ptr - PTR_ONE;
    assign tail_match = (count >= CNT_TWO) && (mem_addr[tail_ptr] == wr_addr);
    assign wr_ready   = ~full | tail_match;
    assign merge      = wr_fire & tail_match;
    assign alloc      = wr_fire & ~tail_match;
`else
    assign wr_ready = ~full;
    assign alloc    = wr_fire;
`endif

    // Next-state and valid: a completion in BUSY restarts directly if work remains.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        valid      = 1'b0;
        more       = (count >= CNT_TWO) | wr_fire;
        case (state)
            ST_IDLE: begin
                if (wr_fire) state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                valid = 1'b1;
                if (ready) state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (ready) begin
                    valid = more;
                    if (!more) state_next = ST_IDLE;
                end else begin
                    valid = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control state: FSM, pointers and occupancy count.
    always_ff @(posedge ap_clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state  <= ST_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (alloc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({alloc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage: allocate at the write pointer, or merge into the tail.
    always_ff @(posedge ap_clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count decide which slots are live.
        if (alloc) begin
            mem_addr[wr_ptr] <= wr_addr;
            mem_data[wr_ptr] <= wr_wdata;
            mem_strb[wr_ptr] <= wr_wstrb;
        end
`ifdef WRITE_BUFFER_COALESCE_EN
        if (merge) begin
            for (int b = 0; b < FE_NBYTES; b++) begin
                if (wr_wstrb[b]) mem_data[tail_ptr][b*8 +: 8] <= wr_wdata[b*8 +: 8];
            end
            mem_strb[tail_ptr] <= mem_strb[tail_ptr] | wr_wstrb;
        end
`endif
    end

endmodule

// File: tb/tb_write_through_buffer.sv
// tb_write_through_buffer: directed and random stimulus against a queue-based
// reference model of the store buffer. Honours WRITE_BUFFER_COALESCE_EN.
module tb_write_through_buffer;

    localparam int WA    = 30;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [WA-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } ent_t;

    logic          ap_clk = 1'b0;
    logic          reset  = 1'b1;
    logic          wr_valid = 1'b0;
    logic [WA-1:0] wr_addr  = '0;
    logic [31:0]   wr_wdata = '0;
    logic [3:0]    wr_wstrb = '0;
    logic          wr_ready;
    logic          valid;
    logic [WA-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          ready = 1'b1;
    logic          empty;
    logic          full;

    int errors = 0;
    int checks = 0;

    // Reference model: pending stores in order, plus "head is in flight".
    ent_t q[$];
    bit   inflight = 0;

    write_through_buffer dut (
        .ap_clk   (ap_clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_wdata (wr_wdata),
        .wr_wstrb (wr_wstrb),
        .wr_ready (wr_ready),
        .valid    (valid),
        .addr     (addr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .ready    (ready),
        .empty    (empty),
        .full     (full)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WA-1:0] waddr(input logic [31:0] byte_addr);
        logic [31:0] w;
        w = byte_addr >> 2;
        return w[WA-1:0];
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic v, input logic [WA-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic r, input string tag);
        int   n;
        bit   match;
        bit   exp_ready;
        bit   exp_valid;
        bit   fire;
        ent_t t;
        wr_valid = v;
        wr_addr  = a;
        wr_wdata = d;
        wr_wstrb = s;
        ready    = r;
        #3;
        n     = q.size();
        match = 0;
`ifdef WRITE_BUFFER_COALESCE_EN
        if (n >= 2) match = (q[n-1].addr == a);
`endif
        exp_ready = (n < DEPTH) || match;
        fire      = v && exp_ready;
        if (n == 0)         exp_valid = 0;
        else if (!inflight) exp_valid = 1;
        else if (!r)        exp_valid = 1;
        else                exp_valid = (n >= 2) || fire;
        check({tag, ".valid"},    32'(valid),    32'(exp_valid));
        check({tag, ".wr_ready"}, 32'(wr_ready), 32'(exp_ready));
        check({tag, ".full"},     32'(full),     32'(n == DEPTH));
        check({tag, ".empty"},    32'(empty),    32'(n == 0));
        if (exp_valid) begin
            check({tag, ".addr"},  32'(addr),  32'(q[0].addr));
            check({tag, ".wdata"}, wdata,      q[0].data);
            check({tag, ".wstrb"}, 32'(wstrb), 32'(q[0].strb));
        end
        @(posedge ap_clk);
        if (fire) begin
            if (match) begin
                t = q[n-1];
                for (int b = 0; b < 4; b++) if (s[b]) t.data[b*8 +: 8] = d[b*8 +: 8];
                t.strb = t.strb | s;
                q[n-1] = t;
            end else begin
                q.push_back('{addr: a, data: d, strb: s});
            end
        end
        if (n > 0 && r) begin
            if (!inflight) begin
                inflight = 1;
            end else begin
                void'(q.pop_front());
                inflight = (q.size() > 0);
            end
        end
        #1;
    endtask

    task automatic idle(input logic r, input string tag);
        cycle(1'b0, '0, 32'h0, 4'h0, r, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1, tag);
        idle(1'b1, tag);
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        wr_valid = 1'b0;
        ready    = 1'b1;
        repeat (n) @(posedge ap_clk);
        #1;
        reset = 1'b0;
        q.delete();
        inflight = 0;
    endtask

    initial begin
        do_reset(2);
        idle(1'b1, "reset");

        // Single store held through a channel transaction.
        cycle(1'b1, waddr(32'h100), 32'hDEADBEEF, 4'hF, 1'b1, "single.push");
        idle(1'b1, "single.present");
        idle(1'b0, "single.busy0");
        idle(1'b0, "single.busy1");
        idle(1'b1, "single.done");
        idle(1'b1, "single.idle");

        // Fill with the channel stalled; a 5th store waits for the first completion.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, waddr(32'h200 + 32'(i) * 4), 32'h1000 + 32'(i), 4'hF, 1'b0, "fill.push");
        cycle(1'b1, waddr(32'h300), 32'h55555555, 4'h5, 1'b0, "fill.blocked");
        cycle(1'b1, waddr(32'h300), 32'h55555555, 4'h5, 1'b1, "fill.start");
        cycle(1'b1, waddr(32'h300), 32'h55555555, 4'h5, 1'b0, "fill.inflight");
        cycle(1'b1, waddr(32'h300), 32'h55555555, 4'h5, 1'b1, "fill.complete");
        cycle(1'b1, waddr(32'h300), 32'h55555555, 4'h5, 1'b0, "fill.accept");
        drain("fill.drain");

        // Burst drain A, B, C with stretched transactions.
        cycle(1'b1, waddr(32'h400), 32'hAAAA0001, 4'hF, 1'b0, "burst.a");
        cycle(1'b1, waddr(32'h404), 32'hBBBB0002, 4'h3, 1'b0, "burst.b");
        cycle(1'b1, waddr(32'h408), 32'hCCCC0003, 4'hC, 1'b0, "burst.c");
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, "burst.ack");
            idle(1'b0, "burst.wait");
        end
        idle(1'b1, "burst.last");
        idle(1'b1, "burst.idle");

        // Push coinciding with the last completion.
        cycle(1'b1, waddr(32'h500), 32'h0D0D0D0D, 4'hF, 1'b1, "simul.d");
        idle(1'b1, "simul.start");
        idle(1'b0, "simul.busy");
        cycle(1'b1, waddr(32'h504), 32'h0E0E0E0E, 4'h9, 1'b1, "simul.push_pop");
        idle(1'b0, "simul.newhead");
        drain("simul.drain");

        // Reset while BUSY with 3 entries, then a plain single store.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, waddr(32'h600 + 32'(i) * 4), 32'h6000 + 32'(i), 4'hF, 1'b0, "rst.fill");
        idle(1'b1, "rst.start");
        idle(1'b0, "rst.busy");
        do_reset(1);
        idle(1'b1, "rst.after");
        cycle(1'b1, waddr(32'h100), 32'hDEADBEEF, 4'hF, 1'b1, "rst.push");
        idle(1'b1, "rst.present");
        idle(1'b0, "rst.busy2");
        idle(1'b1, "rst.done");
        idle(1'b1, "rst.idle");

        // Coalescing candidate: X@0x40, Y@0x80, then 0x80 again with strb 0x3.
        cycle(1'b1, waddr(32'h40), 32'h11111111, 4'hF, 1'b0, "coal.x");
        cycle(1'b1, waddr(32'h80), 32'h22222222, 4'hC, 1'b0, "coal.y");
        cycle(1'b1, waddr(32'h80), 32'h0000AAAA, 4'h3, 1'b0, "coal.merge");
        idle(1'b0, "coal.hold");
        drain("coal.drain");

        // Random traffic on a few addresses so coalescing and full both occur.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), waddr(32'h1000 + 32'($urandom_range(0, 3)) * 4),
                  $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0), "rand");
        end
        drain("rand.drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
